// File: rtl/demux5_pkg.sv
// Shared constants and types for the 1-to-5 stream demultiplexer.
//   NOUT      : number of output streams
//   DROPCNT_W : width of the optional zero-select drop counter
//   sel_t     : one-hot / multi-hot destination select vector
package demux5_pkg;

  localparam int unsigned NOUT      = 5;
  localparam int unsigned DROPCNT_W = 8;

  typedef logic [NOUT-1:0] sel_t;

endpackage : demux5_pkg

// File: rtl/demux5_slot.sv
// One-entry valid/ready holding register for a single demux output.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   load         : capture load_data this cycle (caller guarantees availability)
//   load_data    : beat to capture
//   ready        : downstream consumer ready
//   valid, data  : registered output beat
//   available    : slot can take a beat this cycle (empty or draining)
module demux5_slot #(
  parameter int unsigned DW = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic          available
);

  // Drain and refill in the same cycle is allowed, so a ready consumer frees the slot.
  assign available = ~valid | ready;

  // Valid tracks load/drain; data only changes on load and is kept after drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      if (load) begin
        valid <= 1'b1;
        data  <= load_data;
      end else if (ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule : demux5_slot

// File: rtl/demux5_pipe.sv
// Registered 1-to-5 valid/ready stream demultiplexer with broadcast support.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   in_valid/in_ready : input handshake (in_ready is combinational)
//   in_sel            : destination select, multi-hot broadcasts all-or-nothing
//   in_data           : input beat
//   out_valid/out_ready : per-output handshake, bit i for output i
//   out4..out0        : per-output data from the holding registers
//   drop_count        : saturating count of accepted zero-select beats
//                       (present only when DEMUX5_DROPCNT_EN is defined)
module demux5_pipe
  import demux5_pkg::*;
#(
  parameter int unsigned DW = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  sel_t          in_sel,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output sel_t          out_valid,
  input  sel_t          out_ready,
  output logic [DW-1:0] out4,
  output logic [DW-1:0] out3,
  output logic [DW-1:0] out2,
  output logic [DW-1:0] out1,
  output logic [DW-1:0] out0
`ifdef DEMUX5_DROPCNT_EN
  ,
  output logic [DROPCNT_W-1:0] drop_count
`endif
);

  sel_t          avail;
  sel_t          load;
  logic          accept;
  logic [DW-1:0] slot_data [NOUT];

  // Every selected slot must be free; unselected slots never block.
  assign in_ready = &(~in_sel | avail);
  assign accept   = in_valid & in_ready;
  assign load     = in_sel & {NOUT{accept}};

  // Per-output holding registers.
  for (genvar i = 0; i < NOUT; i++) begin : g_slot
    demux5_slot #(.DW(DW)) u_slot (
      .clk       (clk),
      .reset     (reset),
      .load      (load[i]),
      .load_data (in_data),
      .ready     (out_ready[i]),
      .valid     (out_valid[i]),
      .data      (slot_data[i]),
      .available (avail[i])
    );
  end

  assign out0 = slot_data[0];
  assign out1 = slot_data[1];
  assign out2 = slot_data[2];
  assign out3 = slot_data[3];
  assign out4 = slot_data[4];

`ifdef DEMUX5_DROPCNT_EN
  // Saturating count of beats accepted with no destination.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
    end else if (accept && (in_sel == '0) && (drop_count != {DROPCNT_W{1'b1}})) begin
      drop_count <= drop_count + DROPCNT_W'(1);
    end
  end
`endif

endmodule : demux5_pipe

// File: doc/demux5_pipe.md
Name: demux5_pipe

Overview:
- Registered 1-to-5 stream demultiplexer; the distribution-side counterpart of the one-hot AND-OR 5-input mux in the common library.
- Takes one valid/ready input stream with a one-hot (or multi-hot broadcast) destination select and steers each beat into one of five output streams.
- Each output has a one-entry holding register, so input-to-output latency is one cycle and throughput is full.
- Sits between a single producer and up to five consumers, for example fanning an interconnect channel out to five sub-blocks.

Parameters:
- DW, 1, data width of input and every output.

Ports:
- clk  input  1  clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_sel  input  5  destination select; bit i targets output i; multi-hot = broadcast.
- in_data  input  DW  input beat data.
- in_ready  output  1  input may be accepted this cycle.
- out_valid  output  5  per-output beat valid; bit i for output i.
- out_ready  input  5  per-output consumer ready.
- out4, out3, out2, out1, out0  output  DW each  per-output data, driven from the holding register.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, named reset.
- Reset values: out_valid=5'b0 and out0..out4 all zero. in_ready is combinational, so in_ready=1 while reset is held.
- Slot i is "available" when `!out_valid[i] | out_ready[i]`.
- in_ready is 1 when every slot selected by in_sel is available. With in_sel=0, in_ready=1.
- in_ready depends only on in_sel, out_valid and out_ready; it never depends on in_valid.
- Accept = in_valid & in_ready.
- On accept, every selected slot i loads in_data and sets out_valid[i]=1 on the next edge. Latency is 1 cycle.
- Drain: when out_valid[i] & out_ready[i] and slot i is not loaded this cycle, out_valid[i] clears next edge.
- Simultaneous drain and load on the same slot: out_valid[i] stays 1 and the data updates to the new beat. There is no bubble.
- Broadcast (multi-hot in_sel) is all-or-nothing. If any selected slot is unavailable, nothing is accepted and no selected slot loads.
- in_sel=0 with in_valid=1: the beat is accepted and discarded. No output changes.
- Non-selected slots hold their data and valid unchanged.
- Output data registers load only on accept; they are not cleared on drain.
- Output protocol: once out_valid[i]=1, out_valid[i] and out_i are stable until out_ready[i] is sampled high.
- Reset asserted mid-operation clears all slots immediately (asynchronously). Beats held in slots are lost.
- There is no internal FSM beyond the five independent slot valid bits.

Optional Feature:
- Macro: DEMUX5_DROPCNT_EN.
- Defined:
  - Adds output port drop_count, 8 bits, reset 0.
  - drop_count increments by 1 on each accepted beat with in_sel=0.
  - It saturates at 8'hFF.
- Undefined:
  - The port is absent.
  - Zero-select beats are discarded silently; no extra logic.

Decomposition:
- Shared package demux5_pkg holds:
  - constant NOUT=5;
  - typedef of the 5-bit select vector;
  - constant DROPCNT_W=8.
- Natural sub-module demux5_slot, instantiated five times:
  - a one-entry valid/ready holding register with DW parameter;
  - inputs load/data/ready; outputs valid/data/available.
- The top level computes in_ready as the AND over (~in_sel | available) and generates the per-slot load = accept & in_sel[i].

Test Plan:
- Reset with DW=8: assert reset mid-stream while out_valid=5'b00101 -> out_valid=0 and out0..out4=0 immediately; after release, in_ready=1.
- Single steer: in_sel=5'b00100, in_data=8'hA5, out_ready=5'h1F -> next cycle out_valid=5'b00100, out2=8'hA5; back-to-back beats A5, A6, A7 appear on consecutive cycles with no bubble.
- Backpressure: out_ready[1]=0 with slot 1 full, in_sel=5'b00010 -> in_ready=0 and out1 holds its value. Raise out_ready[1] -> same cycle in_ready=1; next edge loads the new beat.
- Broadcast: in_sel=5'b10001 with slot 4 full and out_ready[4]=0 -> in_ready=0 and slot 0 does not load. Release out_ready[4] -> both out0 and out4 carry the beat.
- Zero select: in_valid=1, in_sel=0 for 3 beats -> in_ready=1 and out_valid unchanged; with DEMUX5_DROPCNT_EN, drop_count=3.
- Saturation (DEMUX5_DROPCNT_EN): 300 zero-select beats -> drop_count=8'hFF.
